// File: rtl/instruction_sequencer.sv
// Purpose: owns program memory and steps 32-bit instructions out to the cpu one at a time.
// Latency: start -> first valid instruction 2 cycles; ISSUE_CYCLES+1 cycles per instruction when not busy.
// Backpressure: cpu_busy_in extends the current instruction's hold; nothing advances while it is high.
module instruction_sequencer #(
  parameter int          DEPTH        = 64,
  parameter int          ADDR_W       = $clog2(DEPTH),
  parameter int          ISSUE_CYCLES = 3,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              load_valid_in,
  input  logic [ADDR_W-1:0] load_addr_in,
  input  logic [31:0]       load_data_in,
  input  logic [ADDR_W:0]   program_length_in,
  input  logic              cpu_busy_in,
  output logic [31:0]       current_instruction,
  output logic              instruction_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              running_out,
  output logic              done_out,
  output logic              halted_out
);

  localparam int                CNT_W     = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(ISSUE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE,
    S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W:0]   len_q;
  logic [CNT_W-1:0]  hold_q;
  logic [31:0]       instr_q;
  logic [31:0]       mem [DEPTH];

  logic        running;
  logic [31:0] fetch_word;
  logic        fetch_halt;
  logic        last_word;
  logic        issue_exit;

  assign running    = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign fetch_word = mem[pc_q];
  assign fetch_halt = (fetch_word == HALT_WORD);
  // Last word either by program length or by running off the top of memory (pc never wraps).
  assign last_word  = (({1'b0, pc_q} + (ADDR_W+1)'(1)) == len_q) || (pc_q == LAST_ADDR);
  assign issue_exit = (state_q == S_ISSUE) && (hold_q == '0) && !cpu_busy_in;

  // Program memory: loader writes only while not sequencing; contents survive reset.
  always_ff @(posedge clock_in) begin
    if (load_valid_in && !running) begin
      mem[load_addr_in] <= load_data_in;
    end
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks start and issue exit.
  always_comb begin
    state_d = state_q;
    if (abort_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_HALTED: begin
          if (start_in) begin
            state_d = (program_length_in == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state_d = fetch_halt ? S_HALTED : S_ISSUE;
        S_ISSUE: begin
          if (issue_exit) begin
            state_d = last_word ? S_DONE : S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: program counter, latched length, hold counter and instruction register.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      pc_q    <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      instr_q <= '0;
    end else if (abort_in) begin
      pc_q   <= '0;
      hold_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_HALTED: begin
          if (start_in) begin
            pc_q  <= '0;
            len_q <= program_length_in;
          end
        end
        S_FETCH: begin
          instr_q <= fetch_word;
          hold_q  <= HOLD_INIT;
        end
        S_ISSUE: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - CNT_W'(1);
          end else if (!cpu_busy_in && !last_word) begin
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the cpu sees NOP whenever nothing is being issued.
  always_comb begin
    current_instruction = '0;
    instruction_valid   = 1'b0;
    pc_out              = pc_q;
    running_out         = running;
    done_out            = (state_q == S_DONE);
    halted_out          = (state_q == S_HALTED);
    if (state_q == S_ISSUE) begin
      current_instruction = instr_q;
      instruction_valid   = 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: expected instructions and hold lengths are queued
// as each program is started; a negedge monitor pops and compares every issued instruction.
module tb_instruction_sequencer;

  localparam int          DEPTH  = 64;
  localparam int          ADDR_W = 6;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h2222_0002, WC = 32'h3333_0003, WD = 32'h4444_0004;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_in = 1'b0, abort_in = 1'b0, load_valid_in = 1'b0, cpu_busy_in = 1'b0;
  logic [ADDR_W-1:0] load_addr_in = '0;
  logic [31:0]       load_data_in = '0;
  logic [ADDR_W:0]   program_length_in = '0;
  logic [31:0]       current_instruction;
  logic              instruction_valid;
  logic [ADDR_W-1:0] pc_out;
  logic              running_out, done_out, halted_out;

  instruction_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ISSUE_CYCLES(3), .HALT_WORD(HALT)) dut (
    .clock_in(clk), .reset_in(rst), .start_in(start_in), .abort_in(abort_in),
    .load_valid_in(load_valid_in), .load_addr_in(load_addr_in), .load_data_in(load_data_in),
    .program_length_in(program_length_in), .cpu_busy_in(cpu_busy_in),
    .current_instruction(current_instruction), .instruction_valid(instruction_valid),
    .pc_out(pc_out), .running_out(running_out), .done_out(done_out), .halted_out(halted_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          len;   // 0 = hold length not checked (interrupted instruction)
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input int len);
    exp_t e;
    e.word = w;
    e.len  = len;
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard pop per valid run, stability within a run, one NOP between runs.
  logic        prev_v  = 1'b0;
  int          run_len = 0;
  int          run_exp = 0;
  int          gap     = 0;
  logic [31:0] run_word = '0;

  always @(negedge clk) begin
    if (instruction_valid) begin
      if (!prev_v) begin
        check("fetch_gap", gap, 1);
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_instr observed=%h expected=none", current_instruction);
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("instr", current_instruction, e.word);
          run_word = e.word;
          run_exp  = e.len;
        end else begin
          run_word = current_instruction;
          run_exp  = 0;
        end
        run_len = 1;
        gap     = 0;
      end else begin
        run_len++;
        check("stable", current_instruction, run_word);
      end
    end else begin
      if (prev_v && run_exp != 0) check("hold_len", run_len, run_exp);
      check("nop_word", current_instruction, 32'h0);
      if (running_out) gap++;
      else gap = 0;
    end
    prev_v = instruction_valid;
  end

  task automatic load(input int addr, input logic [31:0] data);
    @(negedge clk);
    load_valid_in = 1'b1;
    load_addr_in  = ADDR_W'(addr);
    load_data_in  = data;
    @(negedge clk);
    load_valid_in = 1'b0;
  endtask

  task automatic start_prog(input int len);
    @(negedge clk);
    program_length_in = (ADDR_W+1)'(len);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    while (running_out && n < bound) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < bound) else begin
      bad++;
      $error("FAIL run_timeout observed=%0d expected<%0d", n, bound);
    end
  endtask

  task automatic wait_word(input logic [31:0] w);
    int n = 0;
    while (!(instruction_valid && current_instruction === w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 200) else begin
      bad++;
      $error("FAIL word_timeout observed=%h expected=%h", current_instruction, w);
    end
  endtask

  task automatic load_abcd();
    load(0, WA); load(1, WB); load(2, WC); load(3, WD);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", instruction_valid, 0);
    check("rst_instr", current_instruction, 0);
    check("rst_pc", pc_out, 0);
    check("rst_running", running_out, 0);
    check("rst_done", done_out, 0);
    check("rst_halted", halted_out, 0);
    rst = 1'b0;

    // 1: four-word program; load and start while running must be ignored
    load_abcd();
    push(WA, 3); push(WB, 3); push(WC, 3); push(WD, 3);
    start_prog(4);
    check("lat_fetch_running", running_out, 1);
    check("lat_fetch_valid", instruction_valid, 0);
    @(negedge clk);
    check("lat_issue_valid", instruction_valid, 1);
    @(negedge clk);
    load_valid_in = 1'b1; load_addr_in = 6'd2; load_data_in = 32'hDEAD_BEEF; start_in = 1'b1;
    @(negedge clk);
    load_valid_in = 1'b0; start_in = 1'b0;
    wait_end(200);
    check("t1_done", done_out, 1);
    check("t1_halted", halted_out, 0);
    check("t1_pc", pc_out, 3);
    check("t1_sb_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
    check("t1_done_held", done_out, 1);

    // 2: HALT_WORD stops execution without being issued
    load(0, WA); load(1, HALT); load(2, WC);
    push(WA, 3);
    start_prog(3);
    wait_end(200);
    check("t2_halted", halted_out, 1);
    check("t2_done", done_out, 0);
    check("t2_pc", pc_out, 1);
    check("t2_sb_empty", sb.size(), 0);

    // 3: busy during B stretches it to 8 cycles
    load_abcd();
    push(WA, 3); push(WB, 8); push(WC, 3); push(WD, 3);
    start_prog(4);
    wait_word(WB);
    repeat (2) @(negedge clk);
    cpu_busy_in = 1'b1;
    repeat (5) @(negedge clk);
    cpu_busy_in = 1'b0;
    wait_end(200);
    check("t3_done", done_out, 1);
    check("t3_pc", pc_out, 3);
    check("t3_sb_empty", sb.size(), 0);

    // 4: abort in the second cycle of B, then restart from A
    push(WA, 3); push(WB, 2);
    start_prog(4);
    wait_word(WB);
    @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    check("t4_valid", instruction_valid, 0);
    check("t4_instr", current_instruction, 0);
    check("t4_pc", pc_out, 0);
    check("t4_running", running_out, 0);
    check("t4_done", done_out, 0);
    check("t4_sb_empty", sb.size(), 0);
    push(WA, 3); push(WB, 3); push(WC, 3); push(WD, 3);
    start_prog(4);
    wait_end(200);
    check("t4_restart_done", done_out, 1);
    check("t4_restart_sb", sb.size(), 0);

    // 5: asynchronous reset mid-issue; memory must survive
    push(WA, 3); push(WB, 0);
    start_prog(4);
    wait_word(WB);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_valid", instruction_valid, 0);
    check("t5_instr", current_instruction, 0);
    check("t5_running", running_out, 0);
    check("t5_pc", pc_out, 0);
    @(negedge clk);
    rst = 1'b0;
    check("t5_sb_empty", sb.size(), 0);
    push(WA, 3); push(WB, 3); push(WC, 3); push(WD, 3);
    start_prog(4);
    wait_end(200);
    check("t5_mem_done", done_out, 1);
    check("t5_mem_sb", sb.size(), 0);

    // 6: empty program goes straight to DONE; full-depth program issues every word
    start_prog(0);
    check("t6_len0_done", done_out, 1);
    check("t6_len0_running", running_out, 0);
    check("t6_len0_valid", instruction_valid, 0);
    for (int i = 0; i < DEPTH; i++) load(i, 32'hA500_0000 + i);
    for (int i = 0; i < DEPTH; i++) push(32'hA500_0000 + i, 3);
    start_prog(DEPTH);
    wait_end(1000);
    check("t6_full_done", done_out, 1);
    check("t6_full_pc", pc_out, DEPTH - 1);
    check("t6_full_sb", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
